// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch / PC stage of the MIPS core. Holds the architectural PC,
// fetches one instruction word per instruction over a req/ready handshake,
// holds it stable for the decoder while the core executes it, and on
// `advance` computes the next PC from the decoder's pc_control code.
//
// Parameters
//   RESET_PC     PC value loaded on reset.
//
// Ports
//   clk          sole clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   imem_req     fetch request (only in FETCH, forced low while rst=1)
//   imem_addr    byte address of the fetch (always equal to pc)
//   imem_rdata   instruction word from memory
//   imem_ready   memory data valid (same-cycle response allowed)
//   pc_control   000 seq, 001 jump, 010 jump-register, 011 branch, 1xx reserved
//   jr_target    rs register value for JR/JALR
//   advance      single-cycle pulse: core finished executing instr
//   pc           address of the current instruction
//   pc_plus4     pc + 4 (link value for JAL/JALR)
//   instr        held instruction word
//   instr_valid  instr is valid for decode
//   fault        sticky misaligned-target / reserved-control error
//
// Configuration
//   INSTR_FETCH_DELAY_SLOT_EN  when defined, redirects honour a MIPS branch
//                              delay slot: the instruction after a redirect
//                              executes first, then the stored target is used.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic [2:0]  pc_control,
  input  logic [31:0] jr_target,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [2:0] CTRL_SEQ    = 3'b000;
  localparam logic [2:0] CTRL_JUMP   = 3'b001;
  localparam logic [2:0] CTRL_JR     = 3'b010;
  localparam logic [2:0] CTRL_BRANCH = 3'b011;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] instr_next;

  logic [31:0] target;
  logic        reserved;
  logic        misaligned;

`ifdef INSTR_FETCH_DELAY_SLOT_EN
  logic        pend_valid, pend_valid_next;
  logic [31:0] pend_target, pend_target_next;
  logic        is_redirect;
`endif

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Request is gated by rst combinationally so nothing is issued during the
  // reset cycle even though the state register only clears at the edge.
  assign imem_req    = (state == S_FETCH) && !rst;
  assign instr_valid = (state == S_EXEC);
  assign fault       = (state == S_FAULT);

  // ---------------------------------------------------------------------------
  // Target computation from the held instruction and the decoder's code.
  // Reserved codes fall back to pc_plus4, which is also the PC recorded when
  // the reserved-code fault is taken.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    target = pc_plus4;
    case (pc_control)
      CTRL_SEQ:    target = pc_plus4;
      CTRL_JUMP:   target = {pc_plus4[31:28], instr[25:0], 2'b00};
      CTRL_JR:     target = jr_target;
      CTRL_BRANCH: target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      default:     target = pc_plus4;
    endcase
  end

  assign reserved   = pc_control[2];
  assign misaligned = (target[1:0] != 2'b00);

`ifdef INSTR_FETCH_DELAY_SLOT_EN
  assign is_redirect = !pc_control[2] && (pc_control[1:0] != 2'b00);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
`ifdef INSTR_FETCH_DELAY_SLOT_EN
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
`endif

    case (state)
      S_FETCH: begin
        if (imem_ready) begin
          instr_next = imem_rdata;
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        if (advance) begin
`ifdef INSTR_FETCH_DELAY_SLOT_EN
          if (pend_valid) begin
            // Delay-slot instruction retired: the stored target was already
            // checked when it was computed, so no fault test here.
            pc_next         = pend_target;
            pend_valid_next = 1'b0;
            state_next      = S_FETCH;
          end else if (reserved || misaligned) begin
            pc_next    = target;
            state_next = S_FAULT;
          end else if (is_redirect) begin
            pc_next          = pc_plus4;
            pend_target_next = target;
            pend_valid_next  = 1'b1;
            state_next       = S_FETCH;
          end else begin
            pc_next    = target;
            state_next = S_FETCH;
          end
`else
          pc_next    = target;
          state_next = (reserved || misaligned) ? S_FAULT : S_FETCH;
`endif
        end
      end

      S_FAULT: begin
        state_next = S_FAULT;
      end

      default: begin
        state_next = S_FAULT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      instr <= 32'h0;
`ifdef INSTR_FETCH_DELAY_SLOT_EN
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
`endif
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
`ifdef INSTR_FETCH_DELAY_SLOT_EN
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
`endif
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch and PC stage of the MIPS core, directly upstream of the instruction decoder. Holds the architectural PC, fetches each instruction from instruction memory over a request/ready handshake, and presents a stable `instr` to the decoder for the whole execute window. On each `advance` it computes the next PC from the decoder's 3-bit `pc_control` and the held instruction.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request; high only in FETCH and never while `rst`=1.
- `imem_addr`  out  32  byte address of fetch, equal to `pc`.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_req & imem_ready`.
- `imem_ready`  in  1  memory data valid; same-cycle response allowed.
- `pc_control`  in  3  from decoder: 000 seq, 001 jump, 010 jump-register, 011 branch taken, 1xx reserved.
- `jr_target`  in  32  rs register value for JR/JALR.
- `advance`  in  1  core finished executing `instr`; single-cycle pulse.
- `pc`  out  32  address of current instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32 (link value for JAL/JALR).
- `instr`  out  32  held instruction word.
- `instr_valid`  out  1  `instr` is valid for decode.
- `fault`  out  1  sticky misaligned-target or reserved-control error.

## Operation
- States: FETCH, EXEC, FAULT. Reset state FETCH.
- FETCH
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ready`, latch `imem_rdata` into `instr`, set `instr_valid`, go to EXEC.
  - `advance` is ignored.
- EXEC
  - `instr` and `pc` are held stable.
  - On `advance`, compute `next_pc`, clear `instr_valid`, and load `pc` <= `next_pc`. Go to FETCH; go to FAULT instead on error.
- Next-PC computation, all arithmetic 32-bit wrap-around:
  - 000: `pc_plus4`.
  - 001: {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  - 010: `jr_target`.
  - 011: `pc_plus4` + (signext(`instr`[15:0]) << 2).
  - 1xx: error.
- Error: if `next_pc`[1:0] != 0 or the code is reserved, `pc` <= the offending `next_pc` (reserved: `pc_plus4`), set `fault`, and enter FAULT.
- FAULT: `imem_req`=0, `instr_valid`=0, `advance` ignored. Exit only by `rst`.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4, `instr`=0.
  - `instr_valid`=0, `fault`=0, `imem_req`=0.
  - Pending delay-slot state cleared.
- `rst` mid-fetch or mid-execute aborts the operation. Any `imem_ready` in the reset cycle is discarded.
- Fetch latency:
  - `instr_valid` rises on the edge where `imem_req & imem_ready` is sampled.
  - With zero-wait memory, `instr_valid` is high one cycle after entering FETCH.
  - N wait cycles add N.
- `advance` in EXEC:
  - `instr_valid` drops and the new `pc` is visible on the next cycle, together with `imem_req`=1.
  - Minimum instruction period is 2 cycles.
- `pc_control` and `jr_target` are sampled only in the `advance` cycle.
- The decoder is combinational from `instr`, so the inputs must be settled by then.
- `imem_rdata` is ignored when `imem_ready`=0 or outside FETCH.

## Configuration
- `INSTR_FETCH_DELAY_SLOT_EN` defined (MIPS branch delay slot):
  - A redirect (001/010/011) on `advance` loads `pc` <= `pc_plus4` and stores the computed target in a pending register.
  - The next `advance` loads `pc` <= pending target regardless of that instruction's `pc_control`, then clears the pending register.
  - Fault checks apply when the target is computed.
- Undefined: redirects take effect immediately. There is no pending register, and every `advance` uses the current `pc_control`.

## Test plan
- Reset then sequential flow:
  - Stimulus: `RESET_PC`=0, zero-wait memory, `pc_control`=000, three advances.
  - Required: `imem_addr` sequence 0x0, 0x4, 0x8, 0xC; `instr_valid` pulses once per fetch.
- Jump:
  - Stimulus: `pc`=0x0040_0010, `instr`=0x0810_0040 (J), `pc_control`=001, advance.
  - Required: next `pc`=0x0040_0100.
- Branch backward:
  - Stimulus: `pc`=0x100, `instr`[15:0]=0xFFFC, `pc_control`=011, advance.
  - Required: next `pc`=0xF4.
- Wait states and reset:
  - Stimulus: `imem_ready` held low 3 cycles with `advance` pulsed during FETCH.
  - Required: no PC change; `instr_valid` rises on the 4th cycle.
  - Stimulus: `rst` asserted mid-wait.
  - Required: `pc`=`RESET_PC` next cycle.
- Fault:
  - Stimulus: `pc_control`=010, `jr_target`=0x0000_0102, advance.
  - Required: `fault`=1, `pc`=0x102, `imem_req`=0, all later advances ignored until `rst`.
- Delay slot, with macro defined:
  - Stimulus: branch at 0x20 to 0x80.
  - Required: next fetch 0x24, then 0x80.
  - Without the macro, the next fetch is 0x80 directly.
